// File: rtl/mem_burst_master.sv
// Burst master: turns one request into a 1/4/8/16-beat word burst on a simple memory port.
// Define MEM_BURST_PERF_EN to add the saturating beat_count performance counter output.
module mem_burst_master #(
  parameter int data_width    = 32,
  parameter int address_width = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_rw,
  input  logic [address_width-1:0] req_addr,
  input  logic [1:0]               req_size,
  input  logic [data_width-1:0]    wdata,
  output logic                     wdata_pop,
  output logic [data_width-1:0]    rdata,
  output logic                     rdata_valid,
  output logic                     done,
  output logic [address_width-1:0] mem_address,
  output logic [data_width-1:0]    mem_data_in,
  output logic [1:0]               mem_access_size,
  output logic                     mem_rw,
  output logic                     mem_enable,
  output logic                     mem_enable_data_write,
  input  logic                     mem_busy,
  input  logic [data_width-1:0]    mem_data_out
`ifdef MEM_BURST_PERF_EN
  ,output logic [31:0]             beat_count
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RETIRE, FINISH} state_t;

  state_t                   r_state;
  state_t                   w_nextState;
  logic                     w_accept;
  logic                     w_issue;
  logic                     w_idle;
  logic [3:0]               r_beat;
  logic [3:0]               w_lastBeat;
  logic                     r_rw;
  logic [address_width-1:0] r_base;
  logic [1:0]               r_size;
  logic                     r_rdValid;
  logic [address_width-1:0] w_offset;
  logic                     w_unused;

  // Beat sequencing is purely cycle-driven, so the memory's busy flag has no role.
  assign w_unused = mem_busy;

  always_comb begin
    w_lastBeat = 4'd0;
    case (r_size)
      2'b00:   w_lastBeat = 4'd0;
      2'b01:   w_lastBeat = 4'd3;
      2'b10:   w_lastBeat = 4'd7;
      default: w_lastBeat = 4'd15;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        if (r_beat == w_lastBeat) begin
          w_nextState = (r_size == 2'b00) ? FINISH : RETIRE;
        end
      end
      RETIRE:  w_nextState = IDLE;
      FINISH:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_beat    <= 4'd0;
      r_rw      <= 1'b1;
      r_base    <= '0;
      r_size    <= 2'b00;
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= w_issue & r_rw;
      if (w_accept) begin
        r_rw   <= req_rw;
        r_base <= {req_addr[address_width-1:2], 2'b00};
        r_size <= req_size;
        r_beat <= 4'd0;
      end else if (w_issue && (r_beat != w_lastBeat)) begin
        r_beat <= r_beat + 4'd1;
      end else if (done) begin
        r_beat <= 4'd0;
      end
    end
  end

  // RETIRE keeps the final beat's address and size so the memory sees a stable closing cycle.
  assign w_idle                = (r_state == IDLE);
  assign w_issue               = (r_state == ISSUE);
  assign w_offset              = address_width'({r_beat, 2'b00});
  assign req_ready             = w_idle;
  assign done                  = (r_state == RETIRE) || (r_state == FINISH);
  assign mem_enable            = w_issue || (r_state == RETIRE);
  assign mem_address           = w_idle ? '0 : (r_base + w_offset);
  assign mem_rw                = w_idle ? 1'b1 : r_rw;
  assign mem_access_size       = w_idle ? 2'b00 : r_size;
  assign mem_enable_data_write = 1'b0;
  assign mem_data_in           = wdata;
  assign wdata_pop             = w_issue & ~r_rw;
  assign rdata                 = mem_data_out;
  assign rdata_valid           = r_rdValid;

`ifdef MEM_BURST_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_count <= 32'd0;
    end else if (w_issue && (beat_count != 32'hFFFF_FFFF)) begin
      beat_count <= beat_count + 32'd1;
    end
  end
`endif

endmodule
